// File: rtl/mul5b_arb.sv
// Round-robin arbiter that shares one combinational WxW unsigned multiplier between two
// requesters and returns a registered, id-tagged product on a valid/ready port.
module mul5b_arb #(
  parameter int unsigned W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  output logic           gnt0,
  input  logic           req1,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           gnt1,
  output logic [2*W-1:0] p,
  output logic           p_id,
  output logic           p_valid,
  input  logic           p_ready
);

  localparam int unsigned PW = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           op_id;
  logic           last_id;
  logic           pick1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and grants; requester 1 wins a tie only when requester 0 was served last
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    pick1     = req1 & (~req0 | ~last_id);
    case (state)
      IDLE: begin
        if (rst_n) begin
          gnt0 = req0 & ~pick1;
          gnt1 = pick1;
        end
        if (req0 | req1) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (p_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, round-robin pointer and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      op_id   <= 1'b0;
      last_id <= 1'b1;
      p       <= '0;
      p_id    <= 1'b0;
      p_valid <= 1'b0;
    end else begin
      if (gnt0 | gnt1) begin
        op_a    <= gnt1 ? a1 : a0;
        op_b    <= gnt1 ? b1 : b0;
        op_id   <= gnt1;
        last_id <= gnt1;
      end
      if (state == CALC) begin
        p       <= PW'(op_a) * PW'(op_b);
        p_id    <= op_id;
        p_valid <= 1'b1;
      end else if (state == DONE && p_ready) begin
        p_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul5b_arb.sv
// Bench for mul5b_arb: directed vector tables, hand sequences for stall/reset/fairness,
// and randomized traffic checked against a transaction-level reference model.
module tb_mul5b_arb;

  localparam int unsigned W  = 5;
  localparam int unsigned PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, p_ready;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          gnt0, gnt1, p_id, p_valid;
  logic [PW-1:0] p;

  // Wide instance for the full-width product check
  logic          r8, z8, rdy8;
  logic [7:0]    a8, b8, zz8;
  logic          g80, g81, pid8, pv8;
  logic [15:0]   p8;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one outstanding transaction at a time
  bit m_calc, m_valid, m_last, m_id, m_pid;
  int m_prod, m_p;
  bit e_g0, e_g1;
  int gq[$];

  typedef struct {
    bit       rst_before;
    bit       req0;
    bit [4:0] a0, b0;
    bit       req1;
    bit [4:0] a1, b1;
    bit       rdy;
    bit       g0, g1, pv;
    int       p;
    bit       pid;
  } vec_t;

  vec_t tv[11];

  always #5 clk = ~clk;

  mul5b_arb #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .p(p), .p_id(p_id), .p_valid(p_valid), .p_ready(p_ready)
  );

  mul5b_arb #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .req0(r8), .a0(a8), .b0(b8), .gnt0(g80),
    .req1(z8), .a1(zz8), .b1(zz8), .gnt1(g81),
    .p(p8), .p_id(pid8), .p_valid(pv8), .p_ready(rdy8)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_calc  = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b1;
    m_id    = 1'b0;
    m_pid   = 1'b0;
    m_prod  = 0;
    m_p     = 0;
  endfunction

  // Compare DUT outputs with the model for the current cycle's inputs
  task automatic compare_model();
    bit free;
    free = !m_calc && !m_valid;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (free) begin
      if (req0 && req1) begin
        e_g1 = (m_last == 1'b0);
        e_g0 = !e_g1;
      end else begin
        e_g0 = req0;
        e_g1 = req1;
      end
    end
    check("gnt0", int'(gnt0), int'(e_g0));
    check("gnt1", int'(gnt1), int'(e_g1));
    check("p_valid", int'(p_valid), int'(m_valid));
    check("p", int'(p), m_p);
    check("p_id", int'(p_id), int'(m_pid));
    if (gnt0) gq.push_back(0);
    if (gnt1) gq.push_back(1);
  endtask

  // Apply the clock edge to the model, then move just past the DUT edge
  task automatic advance();
    if (m_calc) begin
      m_valid = 1'b1;
      m_p     = m_prod;
      m_pid   = m_id;
      m_calc  = 1'b0;
    end else if (m_valid) begin
      if (p_ready) m_valid = 1'b0;
    end else if (e_g0 || e_g1) begin
      m_calc = 1'b1;
      m_id   = e_g1;
      m_last = e_g1;
      m_prod = e_g1 ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    #1;
    compare_model();
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    p_ready = 1'b0;
    model_reset();
    #2;
    check("rst_gnt0", int'(gnt0), 0);
    check("rst_gnt1", int'(gnt1), 0);
    check("rst_p_valid", int'(p_valid), 0);
    check("rst_p", int'(p), 0);
    check("rst_p_id", int'(p_id), 0);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    r8 = 1'b0; z8 = 1'b0; rdy8 = 1'b1; a8 = 8'd255; b8 = 8'd255; zz8 = 8'd0;

    // Single requester 31*31, then both requesters 3*5 / 7*9 alternating
    tv[0]  = '{1, 1, 5'd31, 5'd31, 0, 5'd0, 5'd0, 1, 1, 0, 0, 0,   0};
    tv[1]  = '{0, 0, 5'd31, 5'd31, 0, 5'd0, 5'd0, 1, 0, 0, 0, 0,   0};
    tv[2]  = '{0, 0, 5'd31, 5'd31, 0, 5'd0, 5'd0, 1, 0, 0, 1, 961, 0};
    tv[3]  = '{0, 0, 5'd31, 5'd31, 0, 5'd0, 5'd0, 1, 0, 0, 0, 961, 0};
    tv[4]  = '{1, 1, 5'd3,  5'd5,  1, 5'd7, 5'd9, 1, 1, 0, 0, 0,   0};
    tv[5]  = '{0, 1, 5'd3,  5'd5,  1, 5'd7, 5'd9, 1, 0, 0, 0, 0,   0};
    tv[6]  = '{0, 1, 5'd3,  5'd5,  1, 5'd7, 5'd9, 1, 0, 0, 1, 15,  0};
    tv[7]  = '{0, 1, 5'd3,  5'd5,  1, 5'd7, 5'd9, 1, 0, 1, 0, 15,  0};
    tv[8]  = '{0, 1, 5'd3,  5'd5,  1, 5'd7, 5'd9, 1, 0, 0, 0, 15,  0};
    tv[9]  = '{0, 1, 5'd3,  5'd5,  1, 5'd7, 5'd9, 1, 0, 0, 1, 63,  1};
    tv[10] = '{0, 1, 5'd3,  5'd5,  1, 5'd7, 5'd9, 1, 1, 0, 0, 63,  1};

    for (int i = 0; i < 11; i++) begin
      if (tv[i].rst_before) do_reset();
      req0 = tv[i].req0; a0 = tv[i].a0; b0 = tv[i].b0;
      req1 = tv[i].req1; a1 = tv[i].a1; b1 = tv[i].b1;
      p_ready = tv[i].rdy;
      #1;
      check($sformatf("tv%0d_gnt0", i), int'(gnt0), int'(tv[i].g0));
      check($sformatf("tv%0d_gnt1", i), int'(gnt1), int'(tv[i].g1));
      check($sformatf("tv%0d_p_valid", i), int'(p_valid), int'(tv[i].pv));
      check($sformatf("tv%0d_p", i), int'(p), tv[i].p);
      check($sformatf("tv%0d_p_id", i), int'(p_id), int'(tv[i].pid));
      compare_model();
      advance();
    end

    // Both requesters held: grants must alternate starting with requester 0
    do_reset();
    req0 = 1'b1; a0 = 5'd2;  b0 = 5'd17;
    req1 = 1'b1; a1 = 5'd30; b1 = 5'd29;
    p_ready = 1'b1;
    gq.delete();
    repeat (18) step();
    check("alt_count", gq.size(), 6);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      check($sformatf("alt_id%0d", i), gq[i], i % 2);

    // Result stalled by p_ready=0; requester 0 raised during DONE must wait
    do_reset();
    req1 = 1'b1; a1 = 5'd0; b1 = 5'd22; p_ready = 1'b0;
    step();
    req1 = 1'b0;
    step();
    req0 = 1'b1; a0 = 5'd7; b0 = 5'd3;
    repeat (6) begin
      step();
      check("stall_p_valid", int'(p_valid), 1);
      check("stall_gnt0", int'(gnt0), 0);
    end
    p_ready = 1'b1;
    step();
    #1;
    check("after_accept_gnt0", int'(gnt0), 1);
    check("after_accept_p", int'(p), 0);
    check("after_accept_p_id", int'(p_id), 1);
    compare_model();
    advance();
    repeat (3) step();

    // Asynchronous reset while in CALC loses the result; held request is re-served
    do_reset();
    req0 = 1'b1; a0 = 5'd12; b0 = 5'd10; p_ready = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_p_valid", int'(p_valid), 0);
    check("async_p", int'(p), 0);
    check("async_gnt0", int'(gnt0), 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    step();
    req0 = 1'b0;
    step();
    #1;
    check("regrant_p_valid", int'(p_valid), 1);
    check("regrant_p", int'(p), 120);
    compare_model();
    advance();

    // Randomized traffic; requesters usually hold until granted
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit g0w, g1w;
      step();
      g0w = e_g0; g1w = e_g1;
      if (g0w || !req0) begin
        req0 = ($urandom_range(0, 2) != 0);
        a0 = W'($urandom); b0 = W'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        req0 = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        a0 = W'($urandom);
      end
      if (g1w || !req1) begin
        req1 = ($urandom_range(0, 2) != 0);
        a1 = W'($urandom); b1 = W'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        req1 = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        b1 = W'($urandom);
      end
      p_ready = ($urandom_range(0, 9) < 7);
    end

    // Full-width product at W=8
    req0 = 1'b0; req1 = 1'b0;
    r8 = 1'b1;
    #1;
    check("w8_gnt0", int'(g80), 1);
    @(posedge clk);
    #1;
    r8 = 1'b0;
    check("w8_calc_p_valid", int'(pv8), 0);
    @(posedge clk);
    #1;
    check("w8_p_valid", int'(pv8), 1);
    check("w8_p", int'(p8), 65025);
    check("w8_p_id", int'(pid8), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
